// File: rtl/reg_port_seq.sv
// Register-file access sequencer: reads operands, performs @Rn+ writeback,
// hands operands to the ALU and writes the ALU result back.
module reg_port_seq #(
  parameter int DW         = 16,
  parameter bit AUTOINC_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_src,
  input  logic [3:0]    req_dst,
  input  logic [1:0]    req_as,
  input  logic          req_bw,
  input  logic          req_wb,
  output logic [3:0]    SA,
  output logic [3:0]    DA,
  output logic [1:0]    As,
  output logic          RW,
  output logic [DW-1:0] Din,
  input  logic [DW-1:0] Sout,
  input  logic [DW-1:0] Dout,
  output logic          opnd_valid,
  input  logic          opnd_ready,
  output logic [DW-1:0] src_val,
  output logic [DW-1:0] dst_val,
  input  logic          res_valid,
  output logic          res_ready,
  input  logic [DW-1:0] res_data,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE, READ, AUTOINC, OPND, WAIT_RES, WB
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    src_q, dst_q;
  logic [1:0]    as_q;
  logic          bw_q, wb_q;
  logic [DW-1:0] res_q;
  logic [DW-1:0] inc;
  logic          autoinc_go;

  // R2/R3 in mode 11 are constant-generator encodings, so they never step.
  assign autoinc_go = AUTOINC_EN && (as_q == 2'b11) &&
                      (src_q != 4'd2) && (src_q != 4'd3);
  assign inc        = (bw_q && (src_q != 4'd1)) ? DW'(1) : DW'(2);

  assign SA   = src_q;
  assign As   = as_q;
  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      as_q    <= '0;
      bw_q    <= 1'b0;
      wb_q    <= 1'b0;
      src_val <= '0;
      dst_val <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        src_q <= req_src;
        dst_q <= req_dst;
        as_q  <= req_as;
        bw_q  <= req_bw;
        wb_q  <= req_wb;
      end
      if (state_q == READ) begin
        src_val <= Sout;
        dst_val <= Dout;
      end
      if (state_q == WAIT_RES && res_valid)
        res_q <= bw_q ? {{(DW-8){1'b0}}, res_data[7:0]} : res_data;
    end
  end

  // RW is decoded from the state register, so an asynchronous reset kills
  // any in-flight write immediately.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    opnd_valid = 1'b0;
    res_ready  = 1'b0;
    RW         = 1'b0;
    DA         = dst_q;
    Din        = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = READ;
      end
      READ: begin
        state_d = autoinc_go ? AUTOINC : OPND;
      end
      AUTOINC: begin
        DA      = src_q;
        RW      = 1'b1;
        Din     = src_val + inc;
        state_d = OPND;
      end
      OPND: begin
        opnd_valid = 1'b1;
        if (opnd_ready) state_d = wb_q ? WAIT_RES : IDLE;
      end
      WAIT_RES: begin
        res_ready = 1'b1;
        if (res_valid) state_d = WB;
      end
      WB: begin
        RW      = 1'b1;
        Din     = res_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_port_seq.sv
// Directed bench for reg_port_seq with a small register-file model and
// scoreboard queues for expected writes and expected operand pairs.
module tb_reg_port_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [3:0]  req_src, req_dst;
  logic [1:0]  req_as;
  logic        req_bw, req_wb;
  logic [3:0]  SA, DA;
  logic [1:0]  As;
  logic        RW;
  logic [15:0] Din, Sout, Dout;
  logic        opnd_valid, opnd_ready;
  logic [15:0] src_val, dst_val;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        busy;

  logic [15:0] rf [16];
  logic        tb_we;
  logic [3:0]  tb_wa;
  logic [15:0] tb_wd;
  logic [15:0] cg;

  logic [19:0] wr_q[$];
  logic [31:0] op_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  reg_port_seq #(.DW(16), .AUTOINC_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .req_as(req_as),
    .req_bw(req_bw), .req_wb(req_wb),
    .SA(SA), .DA(DA), .As(As), .RW(RW), .Din(Din),
    .Sout(Sout), .Dout(Dout),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready),
    .src_val(src_val), .dst_val(dst_val),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  // R3 behaves as the constant generator selected by As.
  always_comb begin
    case (As)
      2'b00:   cg = 16'h0000;
      2'b01:   cg = 16'h0001;
      2'b10:   cg = 16'h0002;
      default: cg = 16'hFFFF;
    endcase
  end
  assign Sout = (SA == 4'd3) ? cg : rf[SA];
  assign Dout = rf[DA];

  always @(posedge clk) begin
    if (RW && DA != 4'd3) rf[DA] <= Din;
    if (tb_we) rf[tb_wa] <= tb_wd;
  end

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write and every operand handoff must be expected.
  always @(negedge clk) begin
    if (rst === 1'b1 && RW === 1'b1) begin
      check_output("wr_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) check_output("wr_data", 32'({DA, Din}), 32'(wr_q.pop_front()));
    end
    if (rst === 1'b1 && opnd_valid === 1'b1 && opnd_ready === 1'b1) begin
      check_output("op_expected", 32'(op_q.size() != 0), 32'd1);
      if (op_q.size() != 0) check_output("op_data", {src_val, dst_val}, op_q.pop_front());
    end
  end

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [3:0] s, input logic [3:0] d,
                                input logic [1:0] a, input logic b, input logic w);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_output("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_src = s; req_dst = d; req_as = a; req_bw = b; req_wb = w;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_output("idle_wait", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_src = '0; req_dst = '0; req_as = '0;
    req_bw = 1'b0; req_wb = 1'b0; opnd_ready = 1'b1; res_valid = 1'b0;
    res_data = '0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    #3;
    check_output("rst_RW", 32'(RW), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_addr", 32'({SA, DA, As}), 32'd0);
    check_output("rst_Din", 32'(Din), 32'd0);
    check_output("rst_vals", {src_val, dst_val}, 32'd0);
    check_output("rst_hs", 32'({opnd_valid, res_ready}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    preload(4'd1, 16'h0100);
    preload(4'd4, 16'hFFFE);
    preload(4'd5, 16'h1234);
    preload(4'd6, 16'h00AA);
    preload(4'd7, 16'h5555);

    $display("[TB] register read");
    op_q.push_back({16'h1234, 16'h00AA});
    apply_stimulus(4'd5, 4'd6, 2'b00, 1'b0, 1'b0);
    check_output("read_addr", 32'({SA, DA, RW}), 32'({4'd5, 4'd6, 1'b0}));
    check_output("read_hs", 32'({busy, req_ready, opnd_valid}), 32'b100);
    @(posedge clk); #1;
    check_output("read_opnd_valid", 32'(opnd_valid), 32'd1);
    @(posedge clk); #1;
    check_output("read_done", 32'(busy), 32'd0);

    $display("[TB] autoincrement word wrap");
    wr_q.push_back({4'd4, 16'h0000});
    op_q.push_back({16'hFFFE, 16'h00AA});
    apply_stimulus(4'd4, 4'd6, 2'b11, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_output("ainc_pulse", 32'({RW, DA, Din}), 32'({1'b1, 4'd4, 16'h0000}));
    @(posedge clk); #1;
    check_output("ainc_single", 32'({RW, opnd_valid}), 32'b01);
    wait_idle();

    $display("[TB] autoincrement byte and SP");
    preload(4'd4, 16'h0200);
    wr_q.push_back({4'd4, 16'h0201});
    op_q.push_back({16'h0200, 16'h00AA});
    apply_stimulus(4'd4, 4'd6, 2'b11, 1'b1, 1'b0);
    wait_idle();
    wr_q.push_back({4'd1, 16'h0102});
    op_q.push_back({16'h0100, 16'h00AA});
    apply_stimulus(4'd1, 4'd6, 2'b11, 1'b1, 1'b0);
    wait_idle();
    check_output("sp_value", 32'(rf[1]), 32'h0102);

    $display("[TB] constant generator");
    op_q.push_back({16'hFFFF, 16'h00AA});
    apply_stimulus(4'd3, 4'd6, 2'b11, 1'b0, 1'b0);
    check_output("cg_as_read", 32'(As), 32'd3);
    @(posedge clk); #1;
    check_output("cg_no_ainc", 32'({As, RW, opnd_valid}), 32'b1101);
    wait_idle();

    $display("[TB] byte writeback with late result");
    wr_q.push_back({4'd7, 16'h00EF});
    op_q.push_back({16'h1234, 16'h5555});
    apply_stimulus(4'd5, 4'd7, 2'b00, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    res_data = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      check_output("wait_res_ready", 32'({res_ready, RW}), 32'b10);
      @(posedge clk); #1;
    end
    res_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    check_output("wb_pulse", 32'({RW, DA, Din}), 32'({1'b1, 4'd7, 16'h00EF}));
    @(posedge clk); #1;
    check_output("wb_single", 32'({RW, busy}), 32'b00);

    $display("[TB] operand stall");
    opnd_ready = 1'b0;
    op_q.push_back({16'h1234, 16'h00AA});
    apply_stimulus(4'd5, 4'd6, 2'b00, 1'b0, 1'b0);
    @(posedge clk); #1;
    preload(4'd5, 16'h9999);
    preload(4'd6, 16'h7777);
    for (int i = 0; i < 2; i++) begin
      check_output("stall_vals", {src_val, dst_val}, {16'h1234, 16'h00AA});
      check_output("stall_hs", 32'({opnd_valid, req_ready}), 32'b10);
      @(posedge clk); #1;
    end
    opnd_ready = 1'b1;
    @(posedge clk); #1;
    check_output("stall_done", 32'({busy, req_ready}), 32'b01);

    $display("[TB] reset during writeback");
    op_q.push_back({16'h9999, 16'h00EF});
    apply_stimulus(4'd5, 4'd7, 2'b00, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    res_valid = 1'b1; res_data = 16'h1111;
    @(posedge clk); #1;
    res_valid = 1'b0;
    check_output("mid_wb_RW", 32'(RW), 32'd1);
    rst = 1'b0;
    #1;
    check_output("async_RW", 32'({RW, busy}), 32'b00);
    check_output("async_vals", {src_val, dst_val}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("post_rst_ready", 32'({req_ready, busy}), 32'b10);
    check_output("no_partial_wr", 32'(rf[7]), 32'h00EF);

    check_output("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check_output("op_q_empty", 32'(op_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
